// File: rtl/timer_periph_pkg.sv
// Shared types and constants for the timer/compare peripheral:
// bus device select, register offsets, CTRL/STATUS bit positions and CTRL layout.
package timer_periph_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      DEV_NONE = 2'd0,
      DEV_MEM  = 2'd1,
      DEV_IO   = 2'd2,
      DEV_ROM  = 2'd3
   } dev_sel_t;

   // Register index, taken from daddress[3:2]
   localparam logic [1:0] TIMER_CTRL    = 2'd0;
   localparam logic [1:0] TIMER_COUNT   = 2'd1;
   localparam logic [1:0] TIMER_COMPARE = 2'd2;
   localparam logic [1:0] TIMER_STATUS  = 2'd3;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_AR_BIT     = 1;
   localparam int CTRL_MIE_BIT    = 2;
   localparam int CTRL_OIE_BIT    = 3;
   localparam int CTRL_PS_LSB     = 8;
   localparam int STAT_MATCH_BIT  = 0;
   localparam int STAT_OVF_BIT    = 1;

   typedef struct packed {
      logic [7:0] prescale;
      logic       ovf_ie;
      logic       match_ie;
      logic       auto_reload;
      logic       en;
   } timer_ctrl_t;

   function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [3:0]        mask);
      logic [DATA_W-1:0] r;
      for (int b = 0; b < 4; b++)
         r[b*8 +: 8] = mask[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
      return r;
   endfunction

endpackage

// File: rtl/timer_periph_if.sv
// CPU data-bus view of the timer peripheral: address, write data/strobe/mask,
// device select, and combinational read data.
interface timer_periph_if;
   import timer_periph_pkg::*;

   logic [DATA_W-1:0] daddress;
   logic [DATA_W-1:0] ddata_w;
   logic              we;
   dev_sel_t          dcsel;
   logic [3:0]        dmask;
   logic [DATA_W-1:0] ddata_r;

   modport master (output daddress, ddata_w, we, dcsel, dmask, input ddata_r);
   modport slave  (input daddress, ddata_w, we, dcsel, dmask, output ddata_r);
endinterface

// File: rtl/timer_periph_prescaler.sv
// Prescaler: pulses tick once every (prescale+1) enabled cycles; held at zero while disabled.
module timer_prescaler (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] prescale,
   output logic       tick
);

   logic [7:0] pcnt_q, pcnt_d;

   assign tick = en && (pcnt_q == prescale);

   always_comb begin
      pcnt_d = pcnt_q + 8'd1;
      if (!en || tick)
         pcnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pcnt_q <= '0;
      else     pcnt_q <= pcnt_d;
   end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer: CTRL/COUNT/COMPARE/STATUS registers, compare-match
// and overflow flags (write-1-to-clear), and a level interrupt built from flops.
module timer_periph
   import timer_periph_pkg::*;
#(
   parameter logic [15:0] ADDR_SEL = 16'h0005
) (
   input  logic           clk,
   input  logic           rst,
   timer_periph_if.slave  bus,
   output logic           irq_out
);

   timer_ctrl_t       ctrl_q, ctrl_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic [DATA_W-1:0] compare_q, compare_d;
   logic [1:0]        status_q, status_d;
   logic [1:0]        flag_set, flag_clr;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        reg_sel;
   logic              addr_hit, wr, tick, unused_addr_bits;

   assign addr_hit         = (bus.daddress[19:4] == ADDR_SEL);
   assign wr               = (bus.dcsel == DEV_IO) && addr_hit && bus.we;
   assign reg_sel          = bus.daddress[3:2];
   assign unused_addr_bits = ^{bus.daddress[31:20], bus.daddress[1:0]};

   always_comb begin
      ctrl_d = ctrl_q;
      if (wr && reg_sel == TIMER_CTRL) begin
         if (bus.dmask[0]) begin
            ctrl_d.en          = bus.ddata_w[CTRL_EN_BIT];
            ctrl_d.auto_reload = bus.ddata_w[CTRL_AR_BIT];
            ctrl_d.match_ie    = bus.ddata_w[CTRL_MIE_BIT];
            ctrl_d.ovf_ie      = bus.ddata_w[CTRL_OIE_BIT];
         end
         if (bus.dmask[1])
            ctrl_d.prescale = bus.ddata_w[CTRL_PS_LSB +: 8];
      end
   end

   // Gating with the next EN value lets a disabling write zero pcnt at its own edge.
   timer_prescaler u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (ctrl_q.en & ctrl_d.en),
      .prescale (ctrl_q.prescale),
      .tick     (tick)
   );

   always_comb begin
      count_d  = count_q;
      flag_set = '0;
      if (tick) begin
         count_d = count_q + 32'd1;
         if (count_q == compare_q) begin
            flag_set[STAT_MATCH_BIT] = 1'b1;
            if (ctrl_q.auto_reload)
               count_d = '0;
         end
         flag_set[STAT_OVF_BIT] = (count_q == '1) && (count_d == '0);
      end
      // A CPU write to COUNT overrides the tick's increment; flags still latch.
      if (wr && reg_sel == TIMER_COUNT)
         count_d = byte_merge(count_q, bus.ddata_w, bus.dmask);
   end

   always_comb begin
      compare_d = compare_q;
      if (wr && reg_sel == TIMER_COMPARE)
         compare_d = byte_merge(compare_q, bus.ddata_w, bus.dmask);
   end

   always_comb begin
      flag_clr = '0;
      if (wr && reg_sel == TIMER_STATUS && bus.dmask[0])
         flag_clr = bus.ddata_w[1:0];
      status_d = (status_q & ~flag_clr) | flag_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q    <= '0;
         count_q   <= '0;
         compare_q <= '0;
         status_q  <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         status_q  <= status_d;
      end
   end

   assign irq_out = (status_q[STAT_MATCH_BIT] & ctrl_q.match_ie) |
                    (status_q[STAT_OVF_BIT]   & ctrl_q.ovf_ie);

   always_comb begin
      rdata = '0;
      if (addr_hit) begin
         case (reg_sel)
            TIMER_CTRL:    rdata = {16'h0, ctrl_q.prescale, 4'h0, ctrl_q.ovf_ie,
                                    ctrl_q.match_ie, ctrl_q.auto_reload, ctrl_q.en};
            TIMER_COUNT:   rdata = count_q;
            TIMER_COMPARE: rdata = compare_q;
            default:       rdata = {30'h0, status_q};
         endcase
      end
   end

   assign bus.ddata_r = rdata;

endmodule

// File: tb/tb_timer_periph.sv
// Directed bench for timer_periph: expected values are queued as stimulus is applied
// and popped when the matching register read or irq sample is taken.
module tb_timer_periph;
   import timer_periph_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0050;

   logic clk = 1'b0;
   logic rst;
   logic irq_out;
   int   n_cmp = 0;
   int   n_mis = 0;
   logic [31:0] exp_q[$];

   timer_periph_if bus_if ();

   timer_periph #(.ADDR_SEL(16'h0005)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if),
      .irq_out (irq_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ra(input logic [1:0] r);
      return BASE | {28'h0, r, 2'b00};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      assert (obs === e) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] e);
      exp_q.push_back(e);
      bus_if.we       = 1'b0;
      bus_if.daddress = addr;
      #1;
      check(tag, bus_if.ddata_r);
   endtask

   task automatic chk_irq(input string tag, input logic e);
      exp_q.push_back({31'h0, e});
      #1;
      check(tag, {31'h0, irq_out});
   endtask

   task automatic wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] m);
      bus_if.daddress = ra(r);
      bus_if.ddata_w  = d;
      bus_if.dmask    = m;
      bus_if.dcsel    = DEV_IO;
      bus_if.we       = 1'b1;
      step();
      bus_if.we       = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      bus_if.daddress = '0;
      bus_if.ddata_w  = '0;
      bus_if.we       = 1'b0;
      bus_if.dcsel    = DEV_IO;
      bus_if.dmask    = 4'hF;
      repeat (2) step();

      // Reset values
      rd("rst_ctrl",   ra(TIMER_CTRL),   32'h0);
      rd("rst_count",  ra(TIMER_COUNT),  32'h0);
      rd("rst_status", ra(TIMER_STATUS), 32'h0);
      chk_irq("rst_irq", 1'b0);
      rst = 1'b0;
      step();

      // Reset pulse mid-count
      wr(TIMER_COUNT, 32'h0000_1234, 4'hF);
      wr(TIMER_CTRL,  32'h0000_0001, 4'hF);
      step();
      step();
      rd("run_count", ra(TIMER_COUNT), 32'h0000_1236);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      rd("rstmid_count",  ra(TIMER_COUNT),  32'h0);
      rd("rstmid_status", ra(TIMER_STATUS), 32'h0);
      rd("rstmid_ctrl",   ra(TIMER_CTRL),   32'h0);
      chk_irq("rstmid_irq", 1'b0);

      // Auto-reload match with PRESCALE=0
      wr(TIMER_COMPARE, 32'h3, 4'hF);
      wr(TIMER_CTRL,    32'h7, 4'hF);
      rd("ar_count0", ra(TIMER_COUNT), 32'h0);
      for (int i = 1; i <= 3; i++) begin
         step();
         rd("ar_count", ra(TIMER_COUNT), 32'(i));
         rd("ar_nomatch", ra(TIMER_STATUS), 32'h0);
      end
      step();
      rd("ar_reload", ra(TIMER_COUNT),  32'h0);
      rd("ar_match",  ra(TIMER_STATUS), 32'h1);
      chk_irq("ar_irq", 1'b1);
      wr(TIMER_STATUS, 32'h1, 4'hF);
      chk_irq("ar_irq_clr", 1'b0);
      rd("ar_status_clr", ra(TIMER_STATUS), 32'h0);
      wr(TIMER_CTRL, 32'h0, 4'hF);

      // Prescaler: PRESCALE=4, COMPARE=1
      wr(TIMER_COUNT,   32'h0, 4'hF);
      wr(TIMER_STATUS,  32'h3, 4'hF);
      wr(TIMER_COMPARE, 32'h1, 4'hF);
      wr(TIMER_CTRL,    32'h0000_0403, 4'hF);
      for (int i = 1; i <= 10; i++) begin
         step();
         rd("ps_count", ra(TIMER_COUNT), (i >= 5 && i < 10) ? 32'h1 : 32'h0);
         rd("ps_match", ra(TIMER_STATUS), (i == 10) ? 32'h1 : 32'h0);
      end
      chk_irq("ps_irq_masked", 1'b0);
      wr(TIMER_CTRL,   32'h0, 4'hF);
      wr(TIMER_STATUS, 32'h3, 4'hF);

      // Overflow
      wr(TIMER_COUNT,   32'hFFFF_FFFF, 4'hF);
      wr(TIMER_COMPARE, 32'h10, 4'hF);
      wr(TIMER_CTRL,    32'h9, 4'hF);
      step();
      rd("ovf_count",  ra(TIMER_COUNT),  32'h0);
      rd("ovf_status", ra(TIMER_STATUS), 32'h2);
      chk_irq("ovf_irq", 1'b1);
      wr(TIMER_CTRL, 32'h0, 4'hF);
      chk_irq("ovf_irq_ie_off", 1'b0);
      wr(TIMER_STATUS, 32'h2, 4'hF);
      rd("ovf_clr", ra(TIMER_STATUS), 32'h0);

      // Byte lanes, unselected accesses
      wr(TIMER_COUNT, 32'h0, 4'hF);
      wr(TIMER_COUNT, 32'hAABB_CCDD, 4'b0011);
      rd("mask_count", ra(TIMER_COUNT), 32'h0000_CCDD);
      wr(TIMER_CTRL, 32'hFFFF_1200, 4'b0010);
      rd("mask_ctrl_ps", ra(TIMER_CTRL), 32'h0000_1200);
      wr(TIMER_COMPARE, 32'hDEAD_BEEF, 4'hF);
      bus_if.dcsel    = DEV_MEM;
      bus_if.daddress = ra(TIMER_COMPARE);
      bus_if.ddata_w  = 32'h1111_1111;
      bus_if.we       = 1'b1;
      step();
      bus_if.we       = 1'b0;
      bus_if.dcsel    = DEV_IO;
      rd("nosel_write", ra(TIMER_COMPARE), 32'hDEAD_BEEF);
      rd("nosel_read",  32'h0000_0068,     32'h0);
      wr(TIMER_CTRL, 32'hFFFF_FFFF, 4'b0001);
      rd("mask_ctrl_lo", ra(TIMER_CTRL), 32'h0000_120F);
      wr(TIMER_CTRL, 32'h0, 4'hF);

      // Collisions: W1C vs new match, COUNT write vs tick
      wr(TIMER_COMPARE, 32'h2, 4'hF);
      wr(TIMER_COUNT,   32'h0, 4'hF);
      wr(TIMER_STATUS,  32'h3, 4'hF);
      wr(TIMER_CTRL,    32'h3, 4'hF);
      repeat (5) step();
      rd("col_pre_count", ra(TIMER_COUNT), 32'h2);
      wr(TIMER_STATUS, 32'h1, 4'hF);
      rd("col_w1c_set_wins", ra(TIMER_STATUS), 32'h1);
      rd("col_reload",       ra(TIMER_COUNT),  32'h0);
      wr(TIMER_COUNT, 32'h50, 4'hF);
      rd("col_count_wr", ra(TIMER_COUNT), 32'h50);
      step();
      rd("col_count_next", ra(TIMER_COUNT), 32'h51);
      wr(TIMER_CTRL, 32'h0, 4'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
